shot_charge_ctrl: RTL and testbench

Keyboard-to-shot front end for the cue ball. It turns level key inputs from the keyboard decoder into single-cycle `chargeUp/Down/Left/Right` and `releaseBall` pulses for the white-ball motion block directly downstream, with frame-based auto-repeat. It tracks a signed per-axis charge level that mirrors the motion block's shot accumulator, and exposes that level to the power-bar drawer. It also locks out aiming while the ball is rolling.

---
 rtl/shot_charge_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_shot_charge_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/shot_charge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shot_charge_ctrl
// Brief    : Cue-ball shot front end. It turns held aim keys into single-cycle
//            charge pulses with frame-based auto-repeat, tracks the per-axis
//            charge level, and issues releaseBall on fire. Optional cancel
//            unwind is built when SHOT_CANCEL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module shot_charge_ctrl #(
    parameter int MAX_STEPS         = 5,
    parameter int INIT_DELAY_FRAMES = 15,
    parameter int REPEAT_FRAMES     = 6,
    parameter int SETTLE_FRAMES     = 4
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              startOfFrame,
    input  logic              keyUp,
    input  logic              keyDown,
    input  logic              keyLeft,
    input  logic              keyRight,
    input  logic              keyFire,
    input  logic              keyCancel,
    input  logic              ballMoving,
    output logic              chargeUp,
    output logic              chargeDown,
    output logic              chargeLeft,
    output logic              chargeRight,
    output logic              releaseBall,
    output logic signed [3:0] chargeLevelX,
    output logic signed [3:0] chargeLevelY,
    output logic              aimEnable
);

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        FIRE   = 2'd1,
        MOVING = 2'd2
`ifdef SHOT_CANCEL_EN
        , CANCEL = 2'd3
`endif
    } state_t;

    localparam logic signed [3:0] c_maxLevel     = 4'(MAX_STEPS);
    localparam logic signed [3:0] c_minLevel     = -c_maxLevel;
    localparam logic        [7:0] c_settleTarget = 8'(SETTLE_FRAMES);

    state_t          r_state;
    logic [1:0]      r_posKeyD;
    logic [1:0]      r_negKeyD;
    logic            r_keyFireD;
    logic            r_fresh;
    logic            r_aim;
    logic            r_release;
    logic [1:0]      r_pulsePos;
    logic [1:0]      r_pulseNeg;
    logic [1:0][7:0] r_holdCnt;
    logic [1:0][3:0] r_level;
    logic [7:0]      r_settleCnt;

    // Axis index 0 is X (Right positive), 1 is Y (Up positive)
    logic [1:0]      w_posKey;
    logic [1:0]      w_negKey;
    logic [1:0]      w_curPos;
    logic [1:0]      w_curNeg;
    logic [1:0]      w_prevPos;
    logic [1:0]      w_prevNeg;
    logic [1:0]      w_same;
    logic [1:0]      w_edge;
    logic [1:0]      w_step;
    logic [1:0]      w_req;
    logic [1:0]      w_doPos;
    logic [1:0]      w_doNeg;
    logic [1:0][7:0] w_holdNext;
    logic [1:0][3:0] w_levelNext;
    logic [7:0]      w_settleNext;
    logic            w_fireReq;

    assign w_posKey = {keyUp, keyRight};
    assign w_negKey = {keyDown, keyLeft};

    function automatic logic isRepeat(input logic [7:0] cnt);
        int c;
        c = int'(cnt);
        return (c >= INIT_DELAY_FRAMES) &&
               (((c - INIT_DELAY_FRAMES) % REPEAT_FRAMES) == 0);
    endfunction

    always_comb begin
        w_curPos    = '0;
        w_curNeg    = '0;
        w_prevPos   = '0;
        w_prevNeg   = '0;
        w_same      = '0;
        w_edge      = '0;
        w_step      = '0;
        w_req       = '0;
        w_doPos     = '0;
        w_doNeg     = '0;
        w_holdNext  = '0;
        w_levelNext = r_level;
        for (int a = 0; a < 2; a++) begin
            w_curPos[a]  = w_posKey[a] & ~w_negKey[a];
            w_curNeg[a]  = w_negKey[a] & ~w_posKey[a];
            // Right after re-arm the history is masked so a held key acts as a new press
            w_prevPos[a] = ~r_fresh & r_posKeyD[a] & ~r_negKeyD[a];
            w_prevNeg[a] = ~r_fresh & r_negKeyD[a] & ~r_posKeyD[a];
            w_same[a]    = (w_curPos[a] & w_prevPos[a]) | (w_curNeg[a] & w_prevNeg[a]);
            w_edge[a]    = (w_curPos[a] | w_curNeg[a]) & ~w_same[a];
            w_step[a]    = w_same[a] & startOfFrame & (r_holdCnt[a] != 8'hFF);

            if (w_step[a])
                w_holdNext[a] = r_holdCnt[a] + 8'd1;
            else if (w_same[a])
                w_holdNext[a] = r_holdCnt[a];

            w_req[a]   = w_edge[a] | (w_step[a] & isRepeat(r_holdCnt[a] + 8'd1));
            w_doPos[a] = w_req[a] & w_curPos[a] & ($signed(r_level[a]) < c_maxLevel);
            w_doNeg[a] = w_req[a] & w_curNeg[a] & ($signed(r_level[a]) > c_minLevel);

            if (w_doPos[a])
                w_levelNext[a] = r_level[a] + 4'd1;
            else if (w_doNeg[a])
                w_levelNext[a] = r_level[a] - 4'd1;
        end
    end

    assign w_fireReq    = keyFire & ~r_keyFireD & ~ballMoving & (r_level != '0);
    assign w_settleNext = r_settleCnt + 8'd1;

`ifdef SHOT_CANCEL_EN
    logic            r_keyCancelD;
    logic [1:0]      w_cancelUp;
    logic [1:0]      w_cancelDown;
    logic [1:0][3:0] w_cancelLevel;
    logic            w_cancelReq;

    always_comb begin
        w_cancelUp    = '0;
        w_cancelDown  = '0;
        w_cancelLevel = r_level;
        for (int a = 0; a < 2; a++) begin
            w_cancelUp[a]   = $signed(r_level[a]) < 4'sd0;
            w_cancelDown[a] = $signed(r_level[a]) > 4'sd0;
            if (w_cancelUp[a])
                w_cancelLevel[a] = r_level[a] + 4'd1;
            else if (w_cancelDown[a])
                w_cancelLevel[a] = r_level[a] - 4'd1;
        end
    end

    assign w_cancelReq = keyCancel & ~r_keyCancelD & (r_level != '0);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            r_keyCancelD <= 1'b0;
        else
            r_keyCancelD <= keyCancel;
    end
`else
    logic w_unusedCancel;
    assign w_unusedCancel = keyCancel;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= ARMED;
            r_posKeyD   <= '0;
            r_negKeyD   <= '0;
            r_keyFireD  <= 1'b0;
            r_fresh     <= 1'b0;
            r_aim       <= 1'b1;
            r_release   <= 1'b0;
            r_pulsePos  <= '0;
            r_pulseNeg  <= '0;
            r_holdCnt   <= '0;
            r_level     <= '0;
            r_settleCnt <= '0;
        end else begin
            r_posKeyD  <= w_posKey;
            r_negKeyD  <= w_negKey;
            r_keyFireD <= keyFire;
            r_pulsePos <= '0;
            r_pulseNeg <= '0;
            r_release  <= 1'b0;

            case (r_state)
                ARMED: begin
                    r_fresh <= 1'b0;
                    // Fire takes priority; any charge edge in the same cycle is dropped
                    if (w_fireReq) begin
                        r_state   <= FIRE;
                        r_release <= 1'b1;
                        r_aim     <= 1'b0;
                    end
`ifdef SHOT_CANCEL_EN
                    else if (w_cancelReq) begin
                        r_state <= CANCEL;
                        r_aim   <= 1'b0;
                    end
`endif
                    else begin
                        r_pulsePos <= w_doPos;
                        r_pulseNeg <= w_doNeg;
                        r_level    <= w_levelNext;
                        r_holdCnt  <= w_holdNext;
                    end
                end

                FIRE: begin
                    r_level     <= '0;
                    r_holdCnt   <= '0;
                    r_settleCnt <= '0;
                    r_state     <= MOVING;
                end

                MOVING: begin
                    if (ballMoving) begin
                        r_settleCnt <= '0;
                    end else if (startOfFrame) begin
                        if (w_settleNext == c_settleTarget) begin
                            r_state     <= ARMED;
                            r_aim       <= 1'b1;
                            r_fresh     <= 1'b1;
                            r_settleCnt <= '0;
                            r_holdCnt   <= '0;
                        end else begin
                            r_settleCnt <= w_settleNext;
                        end
                    end
                end

`ifdef SHOT_CANCEL_EN
                CANCEL: begin
                    r_pulsePos <= w_cancelUp;
                    r_pulseNeg <= w_cancelDown;
                    r_level    <= w_cancelLevel;
                    if (w_cancelLevel == '0) begin
                        r_state   <= ARMED;
                        r_aim     <= 1'b1;
                        r_fresh   <= 1'b1;
                        r_holdCnt <= '0;
                    end
                end
`endif

                default: begin
                    r_state <= ARMED;
                    r_aim   <= 1'b1;
                end
            endcase
        end
    end

    assign chargeRight  = r_pulsePos[0];
    assign chargeUp     = r_pulsePos[1];
    assign chargeLeft   = r_pulseNeg[0];
    assign chargeDown   = r_pulseNeg[1];
    assign releaseBall  = r_release;
    assign chargeLevelX = r_level[0];
    assign chargeLevelY = r_level[1];
    assign aimEnable    = r_aim;

endmodule
`default_nettype wire

// File: tb/tb_shot_charge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shot_charge_ctrl
// Brief    : Self-checking bench for shot_charge_ctrl: vector table plus
//            directed fire/settle, auto-repeat, reset and cancel sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shot_charge_ctrl;

    logic clk = 1'b0;
    logic resetN;
    logic startOfFrame, keyUp, keyDown, keyLeft, keyRight, keyFire, keyCancel, ballMoving;
    logic chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall, aimEnable;
    logic signed [3:0] chargeLevelX, chargeLevelY;

    shot_charge_ctrl dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .keyUp        (keyUp),
        .keyDown      (keyDown),
        .keyLeft      (keyLeft),
        .keyRight     (keyRight),
        .keyFire      (keyFire),
        .keyCancel    (keyCancel),
        .ballMoving   (ballMoving),
        .chargeUp     (chargeUp),
        .chargeDown   (chargeDown),
        .chargeLeft   (chargeLeft),
        .chargeRight  (chargeRight),
        .releaseBall  (releaseBall),
        .chargeLevelX (chargeLevelX),
        .chargeLevelY (chargeLevelY),
        .aimEnable    (aimEnable)
    );

    initial forever #5 clk = ~clk;

    localparam logic [7:0] U = 8'h01, D = 8'h02, L = 8'h04, R = 8'h08;
    localparam logic [7:0] F = 8'h10, C = 8'h20, BM = 8'h40, SOF = 8'h80;
    localparam logic [13:0] M_ALL   = 14'h3FFF;
    localparam logic [13:0] M_NOLVL = 14'h3F00;
    localparam logic [13:0] M_NOAIM = 14'h3EFF;

    // Observed bundle: {release, up, down, left, right, aim, levelX, levelY}
    logic [13:0] obs;
    assign obs = {releaseBall, chargeUp, chargeDown, chargeLeft, chargeRight,
                  aimEnable, chargeLevelX, chargeLevelY};

    int nCmp  = 0;
    int nFail = 0;

    typedef struct {
        logic [7:0]  in;
        logic [13:0] exp;
    } vec_t;

    vec_t tv[20];

    function automatic logic [13:0] ex(input bit rel, input bit u, input bit d,
                                       input bit l, input bit r, input bit aim,
                                       input int lx, input int ly);
        return {rel, u, d, l, r, aim, 4'(lx), 4'(ly)};
    endfunction

    task automatic check(input string name, input logic [13:0] got,
                         input logic [13:0] exp, input logic [13:0] mask);
        nCmp++;
        if ((got & mask) !== (exp & mask)) begin
            nFail++;
            $display("FAIL %s: got %h required %h (mask %h)", name, got & mask, exp & mask, mask);
        end
    endtask

    task automatic drive(input logic [7:0] v);
        {startOfFrame, ballMoving, keyCancel, keyFire, keyRight, keyLeft, keyDown, keyUp} = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] keys, input bit moving);
        for (int c = 0; c < 4; c++) begin
            drive(keys | (moving ? BM : 8'h00) | ((c == 0) ? SOF : 8'h00));
            step();
        end
    endtask

    task automatic asyncReset();
        #2;
        resetN = 1'b0;
        #1;
        check("async_reset", obs, ex(0,0,0,0,0,1,0,0), M_ALL);
        drive(8'h00);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        int bad;
        int lvl;
        bit expP;

        tv[0]  = '{U,     ex(0,1,0,0,0,1, 0,1)};
        tv[1]  = '{8'h00, ex(0,0,0,0,0,1, 0,1)};
        tv[2]  = '{L|R,   ex(0,0,0,0,0,1, 0,1)};
        tv[3]  = '{L|R,   ex(0,0,0,0,0,1, 0,1)};
        tv[4]  = '{L,     ex(0,0,0,1,0,1,-1,1)};
        tv[5]  = '{L,     ex(0,0,0,0,0,1,-1,1)};
        tv[6]  = '{8'h00, ex(0,0,0,0,0,1,-1,1)};
        tv[7]  = '{D|R,   ex(0,0,1,0,1,1, 0,0)};
        tv[8]  = '{8'h00, ex(0,0,0,0,0,1, 0,0)};
        tv[9]  = '{F,     ex(0,0,0,0,0,1, 0,0)};
        tv[10] = '{8'h00, ex(0,0,0,0,0,1, 0,0)};
        tv[11] = '{C,     ex(0,0,0,0,0,1, 0,0)};
        tv[12] = '{8'h00, ex(0,0,0,0,0,1, 0,0)};
        tv[13] = '{L,     ex(0,0,0,1,0,1,-1,0)};
        tv[14] = '{U,     ex(0,1,0,0,0,1,-1,1)};
        tv[15] = '{L,     ex(0,0,0,1,0,1,-2,1)};
        tv[16] = '{U,     ex(0,1,0,0,0,1,-2,2)};
        tv[17] = '{8'h00, ex(0,0,0,0,0,1,-2,2)};
        tv[18] = '{U,     ex(0,1,0,0,0,1,-2,3)};
        tv[19] = '{8'h00, ex(0,0,0,0,0,1,-2,3)};

        resetN = 1'b0;
        drive(8'h00);
        #22;
        check("reset_state", obs, ex(0,0,0,0,0,1,0,0), M_ALL);
        resetN = 1'b1;

        foreach (tv[i]) begin
            drive(tv[i].in);
            step();
            check($sformatf("vec%0d", i), obs, tv[i].exp, M_ALL);
        end

        // Fire edge coinciding with a charge edge: fire wins
        drive(D | F);
        step();
        check("fire_release", obs, ex(1,0,0,0,0,0,0,0), M_NOLVL);
        step();
        check("fire_cleared", obs, ex(0,0,0,0,0,0,0,0), M_ALL);

        bad = 0;
        for (int i = 0; i < 24; i++) begin
            drive(BM | ((i % 4 == 0) ? SOF : 8'h00) | ((i % 2 != 0) ? (U | R | F) : (D | L)));
            step();
            if (obs !== ex(0,0,0,0,0,0,0,0)) bad++;
        end
        check("moving_quiet", 14'(bad), 14'd0, M_ALL);

        // A moving frame in the middle restarts the settle count
        frame(R, 0); frame(R, 0); frame(R, 0);
        frame(R, 1);
        frame(R, 0); frame(R, 0); frame(R, 0);
        check("settle_wait", obs, ex(0,0,0,0,0,0,0,0), M_ALL);
        drive(R | SOF);
        step();
        check("rearm", obs, ex(0,0,0,0,0,1,0,0), M_ALL);
        drive(R);
        step();
        check("rearm_held_key", obs, ex(0,0,0,0,1,1,1,0), M_ALL);

        asyncReset();

        // Auto-repeat: repeats at frames 15, 21, 27, 33; level saturates at +5
        drive(R);
        step();
        check("repeat_edge", obs, ex(0,0,0,0,1,1,1,0), M_ALL);
        lvl = 1;
        bad = 0;
        for (int f = 1; f <= 60; f++) begin
            drive(R | SOF);
            step();
            expP = (f == 15) || (f == 21) || (f == 27) || (f == 33);
            if (expP) lvl++;
            check($sformatf("repeat_f%0d", f), obs, ex(0,0,0,0,expP,1,lvl,0), M_ALL);
            for (int c = 0; c < 3; c++) begin
                drive(R);
                step();
                if (obs !== ex(0,0,0,0,0,1,lvl,0)) bad++;
            end
        end
        check("repeat_quiet", 14'(bad), 14'd0, M_ALL);

        drive(F);
        step();
        check("fire_at_max", obs, ex(1,0,0,0,0,0,0,0), M_NOLVL);
        drive(8'h00);
        step();

        asyncReset();

        // Build X = +3, Y = -1
        drive(R); step(); drive(8'h00); step();
        drive(R); step(); drive(8'h00); step();
        drive(R); step();
        drive(D); step();
        drive(8'h00); step();
        check("cancel_setup", obs, ex(0,0,0,0,0,1,3,-1), M_ALL);

`ifdef SHOT_CANCEL_EN
        drive(C);
        step();
        check("cancel_enter", obs, ex(0,0,0,0,0,0,3,-1), M_ALL);
        step();
        check("cancel_p1", obs, ex(0,1,0,1,0,0,2,0), M_ALL);
        step();
        check("cancel_p2", obs, ex(0,0,0,1,0,0,1,0), M_ALL);
        step();
        check("cancel_p3", obs, ex(0,0,0,1,0,0,0,0), M_NOAIM);
        drive(8'h00);
        step();
        check("cancel_done", obs, ex(0,0,0,0,0,1,0,0), M_ALL);
`else
        drive(C);
        step();
        check("cancel_ignored", obs, ex(0,0,0,0,0,1,3,-1), M_ALL);
        drive(8'h00);
        step();
        check("cancel_ignored2", obs, ex(0,0,0,0,0,1,3,-1), M_ALL);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
`default_nettype wire
